dbg_arb: RTL and testbench
==========================

# dbg_arb

Two-requester arbiter and sequencer for the CPU debug port. Two debug masters share the single stb/we/adr/dat/ack debug bus into the CPU, for example a JTAG-side debug unit and a system-bus debug bridge. The block serialises their accesses with round-robin fairness and aborts accesses that never receive an ack. It also merges the stall requests and latches the breakpoint that drive `cpu_stall_o`.

## Interface
- `ADDR_WIDTH`, 16, debug address width
- `DATA_WIDTH`, 32, debug data width
- `TIMEOUT`, 255, cycles in BUSY without `cpu_ack_i` before abort; 0 disables the timeout
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1, clock; all logic is rising-edge.
- `rstn` in 1, asynchronous active-low reset
- `req0_stb_i`, `req1_stb_i` in 1, access request; held until the matching `ack_o` or `err_o` is seen
- `req0_we_i`, `req1_we_i` in 1, 1 = write
- `req0_adr_i`, `req1_adr_i` in ADDR_WIDTH, address
- `req0_dat_i`, `req1_dat_i` in DATA_WIDTH, write data
- `req0_dat_o`, `req1_dat_o` out DATA_WIDTH, read data; registered
- `req0_ack_o`, `req1_ack_o` out 1, one-cycle completion pulse
- `req0_err_o`, `req1_err_o` out 1, one-cycle timeout-abort pulse
- `req0_stall_i`, `req1_stall_i` in 1, level stall request from each master
- `bp_clr_i` in 1, clears the latched breakpoint
- `bp_o` out 1, latched breakpoint status
- `cpu_bp_i` in 1, CPU breakpoint hit
- `cpu_stall_o` out 1, CPU stall
- `cpu_stb_o`, `cpu_we_o` out 1, debug bus strobe and write enable; registered
- `cpu_adr_o` out ADDR_WIDTH, debug bus address; registered
- `cpu_dat_o` out DATA_WIDTH, debug bus write data; registered
- `cpu_dat_i` in DATA_WIDTH, debug bus read data
- `cpu_ack_i` in 1, debug bus acknowledge

## Operation
- Stall: `cpu_stall_o = cpu_bp_i | bp_hold | req0_stall_i | req1_stall_i`. This path is combinational.
- Breakpoint latch: `bp_hold` sets on `cpu_bp_i`. It clears on `bp_clr_i` only when `cpu_bp_i` is 0, so set wins. `bp_o = bp_hold`.
- FSM states:
  - IDLE: if any `stb` is high, grant a requester. Latch its we/adr/dat into `cpu_*_o` and set `cpu_stb_o=1`. Set `grant` and `last=grant`. Clear the timeout counter. Go to BUSY.
  - BUSY, on `cpu_ack_i`: set `cpu_stb_o=0` and `cpu_we_o=0`. Pulse the granted `ack_o`. If it is a read, load the granted `dat_o` from `cpu_dat_i`. Go to DONE.
  - BUSY, else if `TIMEOUT!=0` and counter==TIMEOUT-1: set `cpu_stb_o=0` and `cpu_we_o=0`. Pulse the granted `err_o`; `dat_o` is unchanged. Go to DONE.
  - BUSY, otherwise: counter increments.
  - DONE: clear the `ack_o`/`err_o` pulse and go to IDLE. The granted requester's `stb` is ignored in this cycle.
- Arbitration: if only one `stb` is high, grant it. If both are high, grant the requester not equal to `last`.
- `cpu_adr_o` and `cpu_dat_o` hold their last values when idle.
- Counter width is `$clog2(TIMEOUT+1)` (minimum 1). It saturates and never wraps.
- Requester inputs are sampled only at grant. Changes to `stb`, adr or dat during BUSY are ignored, and the access completes.
- `ack_o` and `err_o` are never high together and never go to the non-granted requester.

## Timing
- Reset values:
  - all `cpu_*_o`, `req*_ack_o`, `req*_err_o`, `req*_dat_o`, `bp_hold`: 0
  - state: IDLE
  - `last`: 1, so requester 0 wins the first tie
- Grant: `stb` sampled high at edge k → `cpu_stb_o` high after edge k.
- Completion: `cpu_ack_i` sampled at edge k+m → `cpu_stb_o` low and `ack_o` high after k+m, for exactly one cycle.
- Minimum stb-to-ack latency is 2 edges. Minimum spacing between two grants is 3 cycles (IDLE, BUSY, DONE).
- `cpu_ack_i` and timeout on the same edge: the ack wins.
- `cpu_ack_i` in IDLE or DONE: ignored.
- `cpu_bp_i` during BUSY: stall asserts immediately, and the access continues to completion.
- Reset mid-access: all outputs return to their reset values asynchronously, and no `ack_o` or `err_o` is issued.

## Test plan
- Single read, requester 0, adr 0x0010: `cpu_ack_i` 3 cycles after grant with `cpu_dat_i` 0xDEADBEEF. Required: `req0_dat_o`=0xDEADBEEF, one `req0_ack_o` pulse, `cpu_stb_o` high for exactly 3 cycles.
- Simultaneous write requests from both requesters after reset (req0 adr 0x0100/data 0x1, req1 adr 0x0200/data 0x2): req0 is granted first and req1 next. Repeat the tie: req0 is granted first again (alternation). `cpu_adr_o` sequence is 0x0100, 0x0200.
- Timeout, `TIMEOUT`=4, no ack: `cpu_stb_o` high for 4 cycles, then one `req1_err_o` pulse, no `ack_o`, `req1_dat_o` unchanged.
- Ack and timeout on the same edge: only `ack_o` pulses.
- `cpu_bp_i` pulses for one cycle: `cpu_stall_o` and `bp_o` stay 1. `bp_clr_i` drops both to 0 the next cycle. `req0_stall_i`=1 alone forces `cpu_stall_o`=1 combinationally.
- `rstn` low during BUSY: `cpu_stb_o`=0 immediately, and a new request after reset completes normally.

Source files
------------

// File: rtl/dbg_arb.sv
// Two-master round-robin arbiter for the CPU debug bus, with ack timeout
// abort, merged stall requests and a latched breakpoint.
module dbg_arb #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  req0_stb_i,
    input  logic                  req0_we_i,
    input  logic [ADDR_WIDTH-1:0] req0_adr_i,
    input  logic [DATA_WIDTH-1:0] req0_dat_i,
    output logic [DATA_WIDTH-1:0] req0_dat_o,
    output logic                  req0_ack_o,
    output logic                  req0_err_o,
    input  logic                  req0_stall_i,

    input  logic                  req1_stb_i,
    input  logic                  req1_we_i,
    input  logic [ADDR_WIDTH-1:0] req1_adr_i,
    input  logic [DATA_WIDTH-1:0] req1_dat_i,
    output logic [DATA_WIDTH-1:0] req1_dat_o,
    output logic                  req1_ack_o,
    output logic                  req1_err_o,
    input  logic                  req1_stall_i,

    input  logic                  bp_clr_i,
    output logic                  bp_o,
    input  logic                  cpu_bp_i,
    output logic                  cpu_stall_o,

    output logic                  cpu_stb_o,
    output logic                  cpu_we_o,
    output logic [ADDR_WIDTH-1:0] cpu_adr_o,
    output logic [DATA_WIDTH-1:0] cpu_dat_o,
    input  logic [DATA_WIDTH-1:0] cpu_dat_i,
    input  logic                  cpu_ack_i
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                state, state_d;
    logic                  grant, grant_d;
    logic                  last, last_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  bp_hold;
    logic                  sel;

    logic                  stb_d, we_d;
    logic [ADDR_WIDTH-1:0] adr_d;
    logic [DATA_WIDTH-1:0] wdat_d;
    logic [DATA_WIDTH-1:0] rdat0_d, rdat1_d;
    logic                  ack0_d, ack1_d, err0_d, err1_d;

    assign cpu_stall_o = cpu_bp_i | bp_hold | req0_stall_i | req1_stall_i;
    assign bp_o        = bp_hold;

    // Breakpoint latch; a new hit takes priority over a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bp_hold <= 1'b0;
        end else if (cpu_bp_i) begin
            bp_hold <= 1'b1;
        end else if (bp_clr_i) begin
            bp_hold <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            grant      <= 1'b0;
            last       <= 1'b1;
            cnt        <= '0;
            cpu_stb_o  <= 1'b0;
            cpu_we_o   <= 1'b0;
            cpu_adr_o  <= '0;
            cpu_dat_o  <= '0;
            req0_dat_o <= '0;
            req1_dat_o <= '0;
            req0_ack_o <= 1'b0;
            req1_ack_o <= 1'b0;
            req0_err_o <= 1'b0;
            req1_err_o <= 1'b0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last       <= last_d;
            cnt        <= cnt_d;
            cpu_stb_o  <= stb_d;
            cpu_we_o   <= we_d;
            cpu_adr_o  <= adr_d;
            cpu_dat_o  <= wdat_d;
            req0_dat_o <= rdat0_d;
            req1_dat_o <= rdat1_d;
            req0_ack_o <= ack0_d;
            req1_ack_o <= ack1_d;
            req0_err_o <= err0_d;
            req1_err_o <= err1_d;
        end
    end

    always_comb begin
        state_d = state;
        grant_d = grant;
        last_d  = last;
        cnt_d   = cnt;
        stb_d   = cpu_stb_o;
        we_d    = cpu_we_o;
        adr_d   = cpu_adr_o;
        wdat_d  = cpu_dat_o;
        rdat0_d = req0_dat_o;
        rdat1_d = req1_dat_o;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        sel     = 1'b0;

        case (state)
            S_IDLE: begin
                if (req0_stb_i || req1_stb_i) begin
                    // On a tie the requester that did not win last time goes first.
                    sel     = (req0_stb_i && req1_stb_i) ? ~last : req1_stb_i;
                    grant_d = sel;
                    last_d  = sel;
                    stb_d   = 1'b1;
                    we_d    = sel ? req1_we_i  : req0_we_i;
                    adr_d   = sel ? req1_adr_i : req0_adr_i;
                    wdat_d  = sel ? req1_dat_i : req0_dat_i;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cpu_ack_i) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    ack0_d  = ~grant;
                    ack1_d  = grant;
                    if (!cpu_we_o) begin
                        if (grant) rdat1_d = cpu_dat_i;
                        else       rdat0_d = cpu_dat_i;
                    end
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err0_d  = ~grant;
                    err1_d  = grant;
                    state_d = S_DONE;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dbg_arb.sv
// Directed bench for dbg_arb (TIMEOUT=4): reads, round-robin ties, timeout
// abort, ack/timeout collision, breakpoint/stall and mid-access reset.
module tb_dbg_arb;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req0_stb_i, req0_we_i, req0_stall_i;
    logic [AW-1:0] req0_adr_i;
    logic [DW-1:0] req0_dat_i, req0_dat_o;
    logic          req0_ack_o, req0_err_o;
    logic          req1_stb_i, req1_we_i, req1_stall_i;
    logic [AW-1:0] req1_adr_i;
    logic [DW-1:0] req1_dat_i, req1_dat_o;
    logic          req1_ack_o, req1_err_o;
    logic          bp_clr_i, bp_o, cpu_bp_i, cpu_stall_o;
    logic          cpu_stb_o, cpu_we_o, cpu_ack_i;
    logic [AW-1:0] cpu_adr_o;
    logic [DW-1:0] cpu_dat_o, cpu_dat_i;

    int n_chk  = 0;
    int n_pass = 0;

    dbg_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .req0_stb_i(req0_stb_i), .req0_we_i(req0_we_i), .req0_adr_i(req0_adr_i),
        .req0_dat_i(req0_dat_i), .req0_dat_o(req0_dat_o), .req0_ack_o(req0_ack_o),
        .req0_err_o(req0_err_o), .req0_stall_i(req0_stall_i),
        .req1_stb_i(req1_stb_i), .req1_we_i(req1_we_i), .req1_adr_i(req1_adr_i),
        .req1_dat_i(req1_dat_i), .req1_dat_o(req1_dat_o), .req1_ack_o(req1_ack_o),
        .req1_err_o(req1_err_o), .req1_stall_i(req1_stall_i),
        .bp_clr_i(bp_clr_i), .bp_o(bp_o), .cpu_bp_i(cpu_bp_i), .cpu_stall_o(cpu_stall_o),
        .cpu_stb_o(cpu_stb_o), .cpu_we_o(cpu_we_o), .cpu_adr_o(cpu_adr_o),
        .cpu_dat_o(cpu_dat_o), .cpu_dat_i(cpu_dat_i), .cpu_ack_i(cpu_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse status of both requesters packed as {ack1, err1, ack0, err0}.
    function automatic logic [31:0] pulses();
        return {28'd0, req1_ack_o, req1_err_o, req0_ack_o, req0_err_o};
    endfunction

    initial begin
        rstn = 1'b0;
        {req0_stb_i, req0_we_i, req0_stall_i, req1_stb_i, req1_we_i, req1_stall_i} = '0;
        req0_adr_i = '0; req0_dat_i = '0; req1_adr_i = '0; req1_dat_i = '0;
        bp_clr_i = 1'b0; cpu_bp_i = 1'b0; cpu_ack_i = 1'b0; cpu_dat_i = '0;
        step(); step();

        chk("rst_stb",   32'(cpu_stb_o), 0);
        chk("rst_adr",   32'(cpu_adr_o), 0);
        chk("rst_pulse", pulses(), 0);
        chk("rst_stall", 32'(cpu_stall_o), 0);
        rstn = 1'b1;
        step();

        // Single read from requester 0, ack three cycles after grant.
        req0_stb_i = 1'b1; req0_we_i = 1'b0; req0_adr_i = 16'h0010;
        step();
        chk("rd_grant_stb", 32'(cpu_stb_o), 1);
        chk("rd_grant_adr", 32'(cpu_adr_o), 32'h0010);
        chk("rd_grant_we",  32'(cpu_we_o), 0);
        step();
        chk("rd_busy1_stb", 32'(cpu_stb_o), 1);
        step();
        chk("rd_busy2_stb", 32'(cpu_stb_o), 1);
        chk("rd_busy2_pulse", pulses(), 0);
        cpu_ack_i = 1'b1; cpu_dat_i = 32'hDEADBEEF;
        step();
        cpu_ack_i = 1'b0; req0_stb_i = 1'b0; cpu_dat_i = 32'h0BAD0BAD;
        chk("rd_ack_stb",   32'(cpu_stb_o), 0);
        chk("rd_ack_pulse", pulses(), 32'b0010);
        chk("rd_dat",       req0_dat_o, 32'hDEADBEEF);
        step();
        chk("rd_done_pulse", pulses(), 0);
        chk("rd_adr_hold",   32'(cpu_adr_o), 32'h0010);
        // Ack while idle must be ignored.
        cpu_ack_i = 1'b1;
        step();
        cpu_ack_i = 1'b0;
        chk("idle_ack_pulse", pulses(), 0);
        chk("idle_dat_hold",  req0_dat_o, 32'hDEADBEEF);

        // Fresh reset, then tied writes: 0 then 1, and 0 wins the next tie too.
        rstn = 1'b0; step(); rstn = 1'b1; step();
        for (int rep = 0; rep < 2; rep++) begin
            req0_stb_i = 1'b1; req0_we_i = 1'b1; req0_adr_i = 16'h0100; req0_dat_i = 32'h1;
            req1_stb_i = 1'b1; req1_we_i = 1'b1; req1_adr_i = 16'h0200; req1_dat_i = 32'h2;
            step();
            chk("tie_first_adr", 32'(cpu_adr_o), 32'h0100);
            chk("tie_first_dat", cpu_dat_o, 32'h1);
            chk("tie_first_we",  32'(cpu_we_o), 1);
            cpu_ack_i = 1'b1;
            step();
            cpu_ack_i = 1'b0; req0_stb_i = 1'b0;
            chk("tie_first_pulse", pulses(), 32'b0010);
            chk("tie_first_we_lo", 32'(cpu_we_o), 0);
            step();
            chk("tie_done_stb", 32'(cpu_stb_o), 0);
            step();
            chk("tie_second_adr", 32'(cpu_adr_o), 32'h0200);
            chk("tie_second_dat", cpu_dat_o, 32'h2);
            chk("tie_second_stb", 32'(cpu_stb_o), 1);
            cpu_ack_i = 1'b1;
            step();
            cpu_ack_i = 1'b0; req1_stb_i = 1'b0;
            chk("tie_second_pulse", pulses(), 32'b1000);
            chk("tie_wr_dat1", req1_dat_o, 0);
            step();
        end

        // Requester 1 read with minimum latency, to seed req1_dat_o.
        req1_stb_i = 1'b1; req1_we_i = 1'b0; req1_adr_i = 16'h0030;
        step();
        cpu_ack_i = 1'b1; cpu_dat_i = 32'h12345678;
        step();
        cpu_ack_i = 1'b0;
        chk("r1_rd_pulse", pulses(), 32'b1000);
        chk("r1_rd_dat",   req1_dat_o, 32'h12345678);
        step();
        // Requester 1 holds stb with no ack: abort after four busy cycles.
        cpu_dat_i = 32'hFFFF0000;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("to_busy_stb", 32'(cpu_stb_o), 1);
            chk("to_busy_pulse", pulses(), 0);
            step();
        end
        chk("to_busy_stb4", 32'(cpu_stb_o), 1);
        step();
        req1_stb_i = 1'b0;
        chk("to_abort_stb",   32'(cpu_stb_o), 0);
        chk("to_abort_pulse", pulses(), 32'b0100);
        chk("to_abort_dat",   req1_dat_o, 32'h12345678);
        step();
        chk("to_done_pulse", pulses(), 0);

        // Ack arrives on the same edge the timeout would fire.
        req0_stb_i = 1'b1; req0_we_i = 1'b0; req0_adr_i = 16'h0044;
        step();
        step(); step(); step();
        cpu_ack_i = 1'b1; cpu_dat_i = 32'hCAFE0004;
        step();
        cpu_ack_i = 1'b0; req0_stb_i = 1'b0;
        chk("collide_pulse", pulses(), 32'b0010);
        chk("collide_dat",   req0_dat_o, 32'hCAFE0004);
        step();

        // Breakpoint latch, clear, set-over-clear, and master stall.
        cpu_bp_i = 1'b1;
        #1 chk("bp_comb_stall", 32'(cpu_stall_o), 1);
        step();
        cpu_bp_i = 1'b0;
        #1 chk("bp_held_stall", 32'(cpu_stall_o), 1);
        chk("bp_held_bp", 32'(bp_o), 1);
        step();
        chk("bp_still_bp", 32'(bp_o), 1);
        bp_clr_i = 1'b1;
        step();
        bp_clr_i = 1'b0;
        chk("bp_clr_bp",    32'(bp_o), 0);
        #1 chk("bp_clr_stall", 32'(cpu_stall_o), 0);
        cpu_bp_i = 1'b1; bp_clr_i = 1'b1;
        step();
        cpu_bp_i = 1'b0;
        chk("bp_set_wins", 32'(bp_o), 1);
        step();
        bp_clr_i = 1'b0;
        chk("bp_clr2", 32'(bp_o), 0);
        req0_stall_i = 1'b1;
        #1 chk("m0_stall", 32'(cpu_stall_o), 1);
        req0_stall_i = 1'b0;
        #1 chk("m0_stall_off", 32'(cpu_stall_o), 0);
        step();

        // Reset in the middle of an access, then a clean access afterwards.
        req0_stb_i = 1'b1; req0_we_i = 1'b1; req0_adr_i = 16'h0777; req0_dat_i = 32'h77;
        step();
        chk("mid_grant_stb", 32'(cpu_stb_o), 1);
        step();
        rstn = 1'b0;
        #1;
        chk("mid_rst_stb", 32'(cpu_stb_o), 0);
        chk("mid_rst_adr", 32'(cpu_adr_o), 0);
        chk("mid_rst_dat", req0_dat_o, 0);
        req0_stb_i = 1'b0;
        step();
        chk("mid_rst_pulse", pulses(), 0);
        rstn = 1'b1;
        step();
        req1_stb_i = 1'b1; req1_we_i = 1'b0; req1_adr_i = 16'h0055;
        step();
        chk("post_rst_adr", 32'(cpu_adr_o), 32'h0055);
        cpu_ack_i = 1'b1; cpu_dat_i = 32'hA5A5A5A5;
        step();
        cpu_ack_i = 1'b0; req1_stb_i = 1'b0;
        chk("post_rst_pulse", pulses(), 32'b1000);
        chk("post_rst_dat",   req1_dat_o, 32'hA5A5A5A5);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
